// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the decimal display port controller.
// Conversion FSM states, segment patterns and the overflow threshold helper.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Entry n holds the pattern for decimal digit n
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0011000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000011,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // 10^n, used only at elaboration for the overflow threshold (n <= 8 fits)
  function automatic logic [31:0] pow10(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 32'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/seg_port_ctrl_if.sv
// seg_port_ctrl_if: CPU store port plus display outputs of the display controller.
// master = CPU/board side, slave = controller.
interface seg_port_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                  wr_en;
  logic [31:0]           wr_data;
  logic                  busy;
  logic                  overflow;
  logic [6:0]            seg_out;
  logic [NUM_DIGITS-1:0] digit_en;

  modport master (
    output wr_en, wr_data,
    input  busy, overflow, seg_out, digit_en
  );

  modport slave (
    input  wr_en, wr_data,
    output busy, overflow, seg_out, digit_en
  );
endinterface

// File: rtl/seg_digit_enc.sv
// seg_digit_enc: 4-bit digit to active-low 7-segment pattern.
// Non-decimal nibbles render as a blank digit.
module seg_digit_enc
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Table lookup for 0..9, blank for anything else
  always_comb begin
    seg = SEG_BLANK;
    if (digit <= 4'd9) begin
      seg = SEG_TABLE[digit];
    end
  end

endmodule

// File: rtl/seg_port_ctrl.sv
// seg_port_ctrl: memory-mapped decimal display controller.
// A store is converted to BCD by a 32-cycle double-dabble engine, committed
// atomically, then scanned across NUM_DIGITS common-anode digits through one
// shared segment encoder.
// Optional build macro SEG_LZB_EN: leading-zero blanking (digit 0 always shown).
module seg_port_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic          clock,
  input  logic          reset,
  seg_port_ctrl_if.slave bus
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [31:0]      OVF_LIMIT = pow10(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SCAN_DIV - 1);

  state_t                state_reg, state_next;
  logic                  start_conv;
  logic [31:0]           start_data;
  logic [31:0]           shreg_reg;
  logic [BCD_W-1:0]      bcd_reg;
  logic [BCD_W-1:0]      bcd_adj;
  logic [BCD_W+31:0]     dd_shift;
  logic [4:0]            shift_cnt_reg;
  logic                  ovf_tmp_reg;
  logic                  pend_valid_reg;
  logic [31:0]           pend_data_reg;
  logic [BCD_W-1:0]      digits_reg;
  logic                  overflow_reg;
  logic [CNT_W-1:0]      scan_cnt_reg;
  logic [IDX_W-1:0]      scan_idx_reg;
  logic [6:0]            seg_out_reg;
  logic [NUM_DIGITS-1:0] digit_en_reg;
  logic [3:0]            digit_arr [NUM_DIGITS];
  logic [3:0]            cur_digit;
  logic [6:0]            enc_seg;
  logic [6:0]            seg_sel;

  // Per-nibble add-3 correction and a view of the committed digits as an array
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
      assign digit_arr[gi] = digits_reg[4*gi +: 4];
    end
  endgenerate

  // One double-dabble step: shift corrected BCD and the binary source together
  assign dd_shift = {bcd_adj, shreg_reg} << 1;

  // Next state and conversion start selection; a fresh write beats the pending slot
  always_comb begin
    state_next = state_reg;
    start_conv = 1'b0;
    start_data = bus.wr_data;
    case (state_reg)
      IDLE: begin
        if (bus.wr_en) begin
          state_next = CONV;
          start_conv = 1'b1;
        end
      end
      CONV: begin
        if (shift_cnt_reg == 5'd31) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        if (bus.wr_en) begin
          state_next = CONV;
          start_conv = 1'b1;
        end else if (pend_valid_reg) begin
          state_next = CONV;
          start_conv = 1'b1;
          start_data = pend_data_reg;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Conversion datapath, pending slot and atomic commit of the display digits
  always_ff @(posedge clock) begin
    if (reset) begin
      shreg_reg      <= '0;
      bcd_reg        <= '0;
      shift_cnt_reg  <= '0;
      ovf_tmp_reg    <= 1'b0;
      pend_valid_reg <= 1'b0;
      pend_data_reg  <= '0;
      digits_reg     <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      if (start_conv) begin
        shreg_reg     <= start_data;
        bcd_reg       <= '0;
        shift_cnt_reg <= '0;
        ovf_tmp_reg   <= (start_data >= OVF_LIMIT);
      end else if (state_reg == CONV) begin
        bcd_reg       <= dd_shift[BCD_W+31:32];
        shreg_reg     <= dd_shift[31:0];
        shift_cnt_reg <= shift_cnt_reg + 5'd1;
      end

      if (state_reg == COMMIT) begin
        digits_reg     <= bcd_reg;
        overflow_reg   <= ovf_tmp_reg;
        // Any pending value is either consumed now or superseded by a fresh write
        pend_valid_reg <= 1'b0;
      end else if (state_reg == CONV && bus.wr_en) begin
        pend_valid_reg <= 1'b1;
        pend_data_reg  <= bus.wr_data;
      end
    end
  end

  // Shared encoder on the currently scanned digit
  assign cur_digit = digit_arr[scan_idx_reg];

  seg_digit_enc u_enc (
    .digit (cur_digit),
    .seg   (enc_seg)
  );

`ifdef SEG_LZB_EN
  logic [NUM_DIGITS-1:0] digit_shown;

  // A digit is shown if it or any more significant digit is nonzero; digit 0 always
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
      if (gi == 0) begin : g_ones
        assign digit_shown[gi] = 1'b1;
      end else begin : g_upper
        assign digit_shown[gi] = |digits_reg[BCD_W-1:4*gi];
      end
    end
  endgenerate
`endif

  // Final segment pattern: dashes on overflow, optional blanking, else encoded digit
  always_comb begin
    seg_sel = enc_seg;
    if (overflow_reg) begin
      seg_sel = SEG_DASH;
    end
`ifdef SEG_LZB_EN
    else if (!digit_shown[scan_idx_reg]) begin
      seg_sel = SEG_BLANK;
    end
`endif
  end

  // Scan timing; segments and digit select are registered together so they never skew
  always_ff @(posedge clock) begin
    if (reset) begin
      scan_cnt_reg <= '0;
      scan_idx_reg <= '0;
      seg_out_reg  <= SEG_TABLE[0];
      digit_en_reg <= ~NUM_DIGITS'(1);
    end else begin
      if (scan_cnt_reg == LAST_CNT) begin
        scan_cnt_reg <= '0;
        scan_idx_reg <= (scan_idx_reg == LAST_IDX) ? '0 : scan_idx_reg + 1'b1;
      end else begin
        scan_cnt_reg <= scan_cnt_reg + 1'b1;
      end
      seg_out_reg  <= seg_sel;
      digit_en_reg <= ~(NUM_DIGITS'(1) << scan_idx_reg);
    end
  end

  assign bus.busy     = (state_reg != IDLE) | pend_valid_reg;
  assign bus.overflow = overflow_reg;
  assign bus.seg_out  = seg_out_reg;
  assign bus.digit_en = digit_en_reg;

endmodule

// File: tb/tb_seg_port_ctrl.sv
// tb_seg_port_ctrl: directed self-checking bench for seg_port_ctrl
// (NUM_DIGITS=4, SCAN_DIV=4). Expectations follow SEG_LZB_EN when defined.
module tb_seg_port_ctrl;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0011000;
  localparam logic [6:0] DASH = 7'b0111111;
`ifdef SEG_LZB_EN
  localparam logic [6:0] LZ = 7'b1111111;
`else
  localparam logic [6:0] LZ = 7'b1000000;
`endif

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0 = 0;

  always #5 clock = ~clock;

  seg_port_ctrl_if #(.NUM_DIGITS(4)) bus ();

  seg_port_ctrl #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
    $display("check %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic write_val(input logic [31:0] v);
    bus.wr_data = v;
    bus.wr_en   = 1'b1;
    step();
    bus.wr_en   = 1'b0;
  endtask

  // Bounded wait for digit idx to be selected, then check its segments
  task automatic wait_digit(input string tag, input int idx, input logic [6:0] expv);
    logic [3:0] sel;
    bit found;
    sel = ~(4'b0001 << idx);
    found = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.digit_en === sel) begin
        found = 1;
        break;
      end
      step();
    end
    check({tag, "_sel"}, {31'b0, found}, 32'd1);
    check(tag, {25'b0, bus.seg_out}, {25'b0, expv});
  endtask

  initial begin
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    step();
    step();
    check("rst_digit_en", {28'b0, bus.digit_en}, 32'h0000_000e);
    check("rst_seg", {25'b0, bus.seg_out}, {25'b0, S0});
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_ovf", {31'b0, bus.overflow}, 32'd0);

    // Scan cadence: digit 0 held for SCAN_DIV cycles, select lags index by one
    reset = 1'b0;
    repeat (4) step();
    check("scan_hold", {28'b0, bus.digit_en}, 32'h0000_000e);
    step();
    check("scan_adv", {28'b0, bus.digit_en}, 32'h0000_000d);

    // 1234: busy window and scanned digits
    t0 = cyc;
    write_val(32'd1234);
    check("w1234_busy_t1", {31'b0, bus.busy}, 32'd1);
    step_to(t0 + 33);
    check("w1234_busy_t33", {31'b0, bus.busy}, 32'd1);
    step_to(t0 + 34);
    check("w1234_busy_t34", {31'b0, bus.busy}, 32'd0);
    check("w1234_ovf", {31'b0, bus.overflow}, 32'd0);
    step();
    wait_digit("w1234_d0", 0, S4);
    wait_digit("w1234_d1", 1, S3);
    wait_digit("w1234_d2", 2, S2);
    wait_digit("w1234_d3", 3, S1);

    // 10000 overflows: commit edge exactly at end of cycle t0+33
    t0 = cyc;
    write_val(32'd10000);
    step_to(t0 + 33);
    check("w10000_ovf_t33", {31'b0, bus.overflow}, 32'd0);
    step_to(t0 + 34);
    check("w10000_ovf_t34", {31'b0, bus.overflow}, 32'd1);
    step();
    wait_digit("w10000_d0", 0, DASH);
    wait_digit("w10000_d1", 1, DASH);
    wait_digit("w10000_d2", 2, DASH);
    wait_digit("w10000_d3", 3, DASH);

    // 9999 is the largest value that fits
    t0 = cyc;
    write_val(32'd9999);
    step_to(t0 + 34);
    check("w9999_ovf", {31'b0, bus.overflow}, 32'd0);
    step();
    wait_digit("w9999_d0", 0, S9);
    wait_digit("w9999_d1", 1, S9);
    wait_digit("w9999_d2", 2, S9);
    wait_digit("w9999_d3", 3, S9);

    // 5, then 77 and 88 during CONV: 5 commits, then only 88
    t0 = cyc;
    write_val(32'd5);
    write_val(32'd77);
    write_val(32'd88);
    step_to(t0 + 33);
    check("w5_busy_commit", {31'b0, bus.busy}, 32'd1);
    step_to(t0 + 34);
    check("w5_busy_pend", {31'b0, bus.busy}, 32'd1);
    step();
    wait_digit("w5_d0", 0, S5);
    wait_digit("w5_d1", 1, LZ);
    step_to(t0 + 66);
    check("w88_busy_commit", {31'b0, bus.busy}, 32'd1);
    step_to(t0 + 67);
    check("w88_busy_done", {31'b0, bus.busy}, 32'd0);
    step();
    wait_digit("w88_d0", 0, S8);
    wait_digit("w88_d1", 1, S8);

    // 42 written in COMMIT while 17 is pending: 42 wins, 17 discarded
    t0 = cyc;
    write_val(32'd100);
    step_to(t0 + 5);
    write_val(32'd17);
    step_to(t0 + 33);
    write_val(32'd42);
    check("w42_busy_conv", {31'b0, bus.busy}, 32'd1);
    step_to(t0 + 66);
    check("w42_busy_commit", {31'b0, bus.busy}, 32'd1);
    step_to(t0 + 67);
    check("w42_busy_done", {31'b0, bus.busy}, 32'd0);
    step();
    wait_digit("w42_d0", 0, S2);
    wait_digit("w42_d1", 1, S4);
    wait_digit("w42_d2", 2, LZ);

    // 7: single digit, leading digits zero or blank
    t0 = cyc;
    write_val(32'd7);
    step_to(t0 + 34);
    step();
    wait_digit("w7_d0", 0, S7);
    wait_digit("w7_d1", 1, LZ);
    wait_digit("w7_d2", 2, LZ);
    wait_digit("w7_d3", 3, LZ);

    // Reset mid-conversion while overflow is displayed
    t0 = cyc;
    write_val(32'd10000);
    step_to(t0 + 34);
    check("pre_rst_ovf", {31'b0, bus.overflow}, 32'd1);
    t0 = cyc;
    write_val(32'd55);
    step_to(t0 + 10);
    reset = 1'b1;
    step();
    check("mid_rst_digit_en", {28'b0, bus.digit_en}, 32'h0000_000e);
    check("mid_rst_seg", {25'b0, bus.seg_out}, {25'b0, S0});
    check("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
    check("mid_rst_ovf", {31'b0, bus.overflow}, 32'd0);
    reset = 1'b0;
    repeat (40) step();
    check("post_rst_busy", {31'b0, bus.busy}, 32'd0);
    wait_digit("post_rst_d0", 0, S0);
    wait_digit("post_rst_d1", 1, LZ);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_port_ctrl.md
Name: seg_port_ctrl

Overview:
- Memory-mapped decimal display controller for the CPU output port; replaces the per-write combinational divide/modulo path.
- Latches a 32-bit store, converts it to BCD over 32 cycles with a sequential shift-add-3 (double-dabble) engine, and commits the digits atomically.
- Time-multiplexes one shared segment encoder across NUM_DIGITS common-anode digits.

Parameters:
- NUM_DIGITS, 4, digits displayed; legal range 1..8.
- SCAN_DIV, 50000, clock cycles each digit stays selected; must be >= 2.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  one-cycle store strobe from the CPU port decode.
- wr_data  in  32  unsigned value to display.
- busy  out  1  high while a conversion is in progress or pending.
- overflow  out  1  high when the committed value is >= 10^NUM_DIGITS.
- seg_out  out  7  active-low segments {g,f,e,d,c,b,a} for the selected digit.
- digit_en  out  NUM_DIGITS  active-low one-hot digit select; bit 0 is the ones digit.

Behaviour:
- Interface: one clock, `clock`; reset is synchronous and active-high, port `reset`.
- Reset values:
  - state=IDLE, pending cleared.
  - All display digits = 0, overflow=0, scan index=0, scan counter=0.
  - digit_en = ~1, seg_out = 7'b1000000.
- FSM states: IDLE, CONV, COMMIT. busy = (state != IDLE) | pending_valid.
- IDLE + wr_en:
  - Load the shift register with wr_data; clear the BCD accumulator (4*NUM_DIGITS bits).
  - Set ovf_tmp = (wr_data >= 10^NUM_DIGITS); 10^NUM_DIGITS is a constant.
  - Go to CONV with shift count = 0.
- CONV, each cycle:
  - Add 3 to every BCD nibble >= 5.
  - Then shift {bcd, shreg} left by 1.
  - After 32 shifts, go to COMMIT.
  - Latency is fixed at 32 cycles, including the overflow case.
- COMMIT, one cycle:
  - Display digits <= bcd; overflow <= ovf_tmp.
  - If ovf_tmp=1, every digit displays a dash, 7'b0111111.
  - Next state:
    - wr_en this cycle: CONV with wr_data; that write beats the pending slot.
    - else pending_valid: CONV with the pending data.
    - else IDLE.
  - The pending slot is cleared in both CONV cases.
- Timing: wr_en in IDLE at cycle T gives busy high from T+1. Display registers update on the edge ending COMMIT (cycle T+33).
- wr_en during CONV goes to a one-deep pending slot; the last write wins. An in-flight conversion is never aborted by a write.
- Segment encoding, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000011, 7=1111000, 8=0000000, 9=0011000. Nibbles > 9 encode as 1111111.
- Scan:
  - The counter counts 0..SCAN_DIV-1. On wrap, the index advances 0..NUM_DIGITS-1 and then wraps to 0.
  - seg_out and digit_en are registered together, one cycle after the index changes. No cycle may show the new digit_en with the old segments.
- A reset asserted mid-conversion aborts the conversion. Outputs return to their reset values on the next edge.

Optional Feature:
- Macro SEG_LZB_EN.
- Defined: leading-zero blanking. Every digit above the most significant nonzero digit outputs 1111111. Digit 0 is always shown, so a value of 0 shows a single "0". Dashes during overflow are unaffected.
- Undefined: all NUM_DIGITS digits are always shown, including leading zeros.

Decomposition:
- Shared package seg_pkg:
  - state enum {IDLE, CONV, COMMIT}.
  - SEG_BLANK=7'b1111111, SEG_DASH=7'b0111111.
  - The 10-entry segment constant table.
  - Function pow10(n) for the overflow threshold.
- Sub-module seg_digit_enc: combinational 4-bit digit to 7-bit active-low segment encoder, instantiated once on the muxed digit.

Test Plan:
- Reset -> digit_en=4'b1110, seg_out=7'b1000000, busy=0, overflow=0 (NUM_DIGITS=4, SCAN_DIV=4).
- Write 1234 in IDLE at T -> busy high T+1..T+33; scan then shows 4,3,2,1 as 0011001, 0110000, 0100100, 1111001; overflow=0.
- Write 10000 -> after 33 cycles overflow=1, every digit shows 0111111. Then write 9999 -> overflow=0, all digits 0011000.
- Write 5, then 77 and 88 during CONV -> committed 5, then a single further conversion commits 88; busy drops only after 88 commits.
- wr_en=42 exactly in the COMMIT cycle while pending holds 17 -> 42 is converted and displayed, 17 is discarded.
- With SEG_LZB_EN, write 7 -> digits 3..1 show 1111111, digit 0 shows 1111000. Reset asserted mid-CONV -> next cycle all outputs are at their reset values and busy=0.
